// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel renderers and the DAC.
// The generator drives every signal; renderers and the DAC only observe.
interface vga_timing_gen_if;
   logic       vga_clk;
   logic       hsync;
   logic       vsync;
   logic       active_pixels;
   logic [9:0] xPixel;
   logic [9:0] yPixel;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;
   logic       line_start;
   logic       frame_start;

   modport master (
      output vga_clk, hsync, vsync, active_pixels, xPixel, yPixel,
             VGA_BLANK_N, VGA_SYNC_N, line_start, frame_start
   );

   modport slave (
      input  vga_clk, hsync, vsync, active_pixels, xPixel, yPixel,
             VGA_BLANK_N, VGA_SYNC_N, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clk/2 pixel clock, h/v counters with region FSMs, sync/blank and strobes.
// All outputs are registered on the advance edge and describe the new (h,v) position.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
   localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
   localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      H_ST_ACT  = 2'd0,
      H_ST_FP   = 2'd1,
      H_ST_SYNC = 2'd2,
      H_ST_BP   = 2'd3
   } h_state_t;

   typedef enum logic [1:0] {
      V_ST_ACT  = 2'd0,
      V_ST_FP   = 2'd1,
      V_ST_SYNC = 2'd2,
      V_ST_BP   = 2'd3
   } v_state_t;

   logic       r_pix_en;
   logic [9:0] r_h;
   logic [9:0] r_v;
   h_state_t   r_h_state;
   v_state_t   r_v_state;
   logic [9:0] r_x;
   logic [9:0] r_y;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_active;
   logic       r_line_start;
   logic       r_frame_start;

   logic       w_h_wrap;
   logic [9:0] w_h_next;
   logic [9:0] w_v_next;
   h_state_t   w_h_state_next;
   v_state_t   w_v_state_next;

   // Counter successors: h wraps at H_LAST, v steps only on the h wrap.
   always_comb begin
      w_h_wrap = (r_h == H_LAST);
      if (w_h_wrap) begin
         w_h_next = 10'd0;
         if (r_v == V_LAST) begin
            w_v_next = 10'd0;
         end else begin
            w_v_next = r_v + 10'd1;
         end
      end else begin
         w_h_next = r_h + 10'd1;
         w_v_next = r_v;
      end
   end

   // Horizontal region transitions, keyed on the position being entered.
   always_comb begin
      w_h_state_next = r_h_state;
      case (r_h_state)
         H_ST_ACT: begin
            if (w_h_next == H_FP_START) w_h_state_next = H_ST_FP;
            else                        w_h_state_next = H_ST_ACT;
         end
         H_ST_FP: begin
            if (w_h_next == H_SYNC_START) w_h_state_next = H_ST_SYNC;
            else                          w_h_state_next = H_ST_FP;
         end
         H_ST_SYNC: begin
            if (w_h_next == H_BP_START) w_h_state_next = H_ST_BP;
            else                        w_h_state_next = H_ST_SYNC;
         end
         H_ST_BP: begin
            if (w_h_next == 10'd0) w_h_state_next = H_ST_ACT;
            else                   w_h_state_next = H_ST_BP;
         end
         default: w_h_state_next = H_ST_BP;
      endcase
   end

   // Vertical region transitions; the vertical FSM only moves when the line wraps.
   always_comb begin
      w_v_state_next = r_v_state;
      if (w_h_wrap) begin
         case (r_v_state)
            V_ST_ACT: begin
               if (w_v_next == V_FP_START) w_v_state_next = V_ST_FP;
               else                        w_v_state_next = V_ST_ACT;
            end
            V_ST_FP: begin
               if (w_v_next == V_SYNC_START) w_v_state_next = V_ST_SYNC;
               else                          w_v_state_next = V_ST_FP;
            end
            V_ST_SYNC: begin
               if (w_v_next == V_BP_START) w_v_state_next = V_ST_BP;
               else                        w_v_state_next = V_ST_SYNC;
            end
            V_ST_BP: begin
               if (w_v_next == 10'd0) w_v_state_next = V_ST_ACT;
               else                   w_v_state_next = V_ST_BP;
            end
            default: w_v_state_next = V_ST_BP;
         endcase
      end else begin
         w_v_state_next = r_v_state;
      end
   end

   // Pixel-enable divider, counters, region FSMs and registered raster outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pix_en      <= 1'b0;
         r_h           <= H_LAST;
         r_v           <= V_LAST;
         r_h_state     <= H_ST_BP;
         r_v_state     <= V_ST_BP;
         r_x           <= 10'd0;
         r_y           <= 10'd0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_active      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_en <= ~r_pix_en;
         if (r_pix_en) begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_h_state     <= w_h_state_next;
            r_v_state     <= w_v_state_next;
            r_x           <= w_h_next;
            r_y           <= w_v_next;
            r_hsync       <= (w_h_state_next == H_ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_v_state_next == V_ST_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_active      <= (w_h_state_next == H_ST_ACT) && (w_v_state_next == V_ST_ACT);
            r_line_start  <= (w_h_next == 10'd0);
            r_frame_start <= (w_h_next == 10'd0) && (w_v_next == 10'd0);
         end else begin
            // Strobes last exactly one clk: clear them on the non-advance edge.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
         end
      end
   end

   assign vga.vga_clk       = r_pix_en;
   assign vga.hsync         = r_hsync;
   assign vga.vsync         = r_vsync;
   assign vga.active_pixels = r_active;
   assign vga.VGA_BLANK_N   = r_active;
   assign vga.VGA_SYNC_N    = 1'b0;
   assign vga.xPixel        = r_x;
   assign vga.yPixel        = r_y;
   assign vga.line_start    = r_line_start;
   assign vga.frame_start   = r_frame_start;

endmodule
